fork_join_dispatcher: RTL and testbench

- Hardware counterpart of the fork/join task launcher: accepts one "fork" command carrying up to NUM_JOBS job delays and a join mode.
- Runs all enabled jobs concurrently as countdown timers and signals the join point per mode (all, any, none).
- Streams per-job completion events with timestamps to a downstream logger/display stage.
- Sits between the test sequencer (upstream) and the event logger (downstream).

---
 rtl/fork_join_dispatcher_pkg.sv | 29 ++
 rtl/fork_join_dispatcher_if.sv | 37 +++
 rtl/fork_join_dispatcher_job_timer.sv | 47 ++++
 rtl/fork_join_dispatcher.sv | 142 ++++++++++++++
 tb/tb_fork_join_dispatcher.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fork_join_dispatcher_pkg.sv
// Shared encodings and default widths for the fork/join dispatcher and its job timers.
package fork_join_pkg;

  localparam int DEF_NUM_JOBS = 4;
  localparam int DEF_DELAY_W  = 8;
  localparam int DEF_TIME_W   = 16;
  localparam int DEF_ID_W     = 2;

  typedef enum logic [1:0] {
    JOIN_ALL  = 2'd0,
    JOIN_ANY  = 2'd1,
    JOIN_NONE = 2'd2,
    JOIN_RSVD = 2'd3
  } join_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // The reserved encoding behaves exactly like JOIN_ALL.
  function automatic join_mode_t norm_mode(input logic [1:0] mode);
    join_mode_t m;
    m = join_mode_t'(mode);
    return (m == JOIN_ANY || m == JOIN_NONE) ? m : JOIN_ALL;
  endfunction

endpackage

// File: rtl/fork_join_dispatcher_if.sv
// Fork command, join/busy status and completion-event stream of the dispatcher.
interface fork_join_dispatcher_if
  import fork_join_pkg::*;
#(
  parameter int NUM_JOBS = DEF_NUM_JOBS,
  parameter int DELAY_W  = DEF_DELAY_W,
  parameter int TIME_W   = DEF_TIME_W,
  parameter int ID_W     = DEF_ID_W
) ();

  // Handshakes (fork_*, evt_*): a transfer happens on a rising clock edge where
  // valid && ready; the sender holds payload stable while valid && !ready, and
  // valid never depends combinationally on ready.
  logic                         fork_valid;
  logic                         fork_ready;
  logic [1:0]                   fork_mode;
  logic [NUM_JOBS-1:0]          fork_en;
  logic [NUM_JOBS*DELAY_W-1:0]  fork_delay;
  logic                         join_done;
  logic [NUM_JOBS-1:0]          busy;
  logic                         evt_valid;
  logic                         evt_ready;
  logic [ID_W-1:0]              evt_id;
  logic [TIME_W-1:0]            evt_time;
  logic [TIME_W-1:0]            now;

  modport slave (
    input  fork_valid, fork_mode, fork_en, fork_delay, evt_ready,
    output fork_ready, join_done, busy, evt_valid, evt_id, evt_time, now
  );

  modport master (
    output fork_valid, fork_mode, fork_en, fork_delay, evt_ready,
    input  fork_ready, join_done, busy, evt_valid, evt_id, evt_time, now
  );

endinterface

// File: rtl/fork_join_dispatcher_job_timer.sv
// One job slot: countdown from the loaded delay (0 counts as 1), done pulse on the
// final count, completion timestamp latched and also bypassed on the done cycle.
module job_timer #(
  parameter int DELAY_W = 8,
  parameter int TIME_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic [DELAY_W-1:0] i_delay,
  input  logic [TIME_W-1:0]  i_now,
  output logic               o_busy,
  output logic               o_done,
  output logic [TIME_W-1:0]  o_time
);

  logic [DELAY_W-1:0] r_cnt;
  logic               r_busy;
  logic [TIME_W-1:0]  r_time;
  logic               w_done;

  assign w_done = r_busy && (r_cnt == DELAY_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_time <= '0;
    end else if (i_load) begin
      r_busy <= 1'b1;
      r_cnt  <= (i_delay == '0) ? DELAY_W'(1) : i_delay;
    end else if (r_busy) begin
      if (w_done) begin
        r_busy <= 1'b0;
        r_time <= i_now;
      end else begin
        r_cnt <= r_cnt - DELAY_W'(1);
      end
    end
  end

  assign o_busy = r_busy;
  assign o_done = w_done;
  // The event register may capture a completion in its own cycle, before r_time updates.
  assign o_time = w_done ? i_now : r_time;

endmodule

// File: rtl/fork_join_dispatcher.sv
// Fork/join dispatcher: launches enabled job timers, signals the join point per mode
// and streams per-job completion events (lowest index first) with timestamps.
module fork_join_dispatcher
  import fork_join_pkg::*;
#(
  parameter int NUM_JOBS = DEF_NUM_JOBS,
  parameter int DELAY_W  = DEF_DELAY_W,
  parameter int TIME_W   = DEF_TIME_W,
  parameter int ID_W     = DEF_ID_W
) (
  input  logic                  clk,
  input  logic                  rst,
  fork_join_dispatcher_if.slave bus,
  output state_t                o_dbg_state
);

  state_t              r_state;
  state_t              w_state_nxt;
  join_mode_t          r_mode;
  logic [NUM_JOBS-1:0] r_en;
  logic [NUM_JOBS-1:0] r_comp;
  logic [NUM_JOBS-1:0] r_pend;
  logic [TIME_W-1:0]   r_now;
  logic                r_evt_valid;
  logic [ID_W-1:0]     r_evt_id;
  logic [TIME_W-1:0]   r_evt_time;

  logic [NUM_JOBS-1:0] w_busy;
  logic [NUM_JOBS-1:0] w_done;
  logic [NUM_JOBS-1:0] w_avail;
  logic [NUM_JOBS-1:0] w_pick_mask;
  logic [TIME_W-1:0]   w_ts [NUM_JOBS];
  logic [ID_W-1:0]     w_pick_id;
  logic                w_ready;
  logic                w_accept;
  logic                w_cond;
  logic                w_join;
  logic                w_evt_load;

  always_ff @(posedge clk) begin
    if (rst) r_now <= '0;
    else     r_now <= r_now + TIME_W'(1);
  end

  for (genvar g = 0; g < NUM_JOBS; g++) begin : g_slot
    job_timer #(.DELAY_W(DELAY_W), .TIME_W(TIME_W)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_accept && bus.fork_en[g]),
      .i_delay (bus.fork_delay[g*DELAY_W +: DELAY_W]),
      .i_now   (r_now),
      .o_busy  (w_busy[g]),
      .o_done  (w_done[g]),
      .o_time  (w_ts[g])
    );
  end

  assign w_ready  = !rst && (r_state == IDLE) && (w_busy == '0) && (r_pend == '0);
  assign w_accept = bus.fork_valid && w_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode <= JOIN_ALL;
      r_en   <= '0;
      r_comp <= '0;
    end else if (w_accept) begin
      r_mode <= norm_mode(bus.fork_mode);
      r_en   <= bus.fork_en;
      r_comp <= '0;
    end else begin
      r_comp <= r_comp | w_done;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Join conditions count a slot completing this very cycle, so the pulse lands on T+d.
  always_comb begin
    w_state_nxt = r_state;
    w_cond      = 1'b0;
    w_join      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_nxt = RUN;
      end
      RUN: begin
        if (r_en == '0 || r_mode == JOIN_NONE) w_cond = 1'b1;
        else if (r_mode == JOIN_ANY)           w_cond = |(r_en & w_done);
        else                                   w_cond = &(~r_en | r_comp | w_done);
        if (w_cond) begin
          w_join      = 1'b1;
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (w_busy == '0 && r_pend == '0 && !r_evt_valid) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_avail   = r_pend | w_done;
    w_pick_id = '0;
    for (int i = NUM_JOBS - 1; i >= 0; i--) begin
      if (w_avail[i]) w_pick_id = ID_W'(i);
    end
    w_pick_mask = NUM_JOBS'(1) << w_pick_id;
    w_evt_load  = (!r_evt_valid || bus.evt_ready) && (w_avail != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend      <= '0;
      r_evt_valid <= 1'b0;
      r_evt_id    <= '0;
      r_evt_time  <= '0;
    end else begin
      r_pend <= w_avail & ~(w_evt_load ? w_pick_mask : '0);
      if (w_evt_load) begin
        r_evt_valid <= 1'b1;
        r_evt_id    <= w_pick_id;
        r_evt_time  <= w_ts[w_pick_id];
      end else if (bus.evt_ready) begin
        r_evt_valid <= 1'b0;
      end
    end
  end

  assign bus.fork_ready = w_ready;
  assign bus.join_done  = w_join && !rst;
  assign bus.busy       = w_busy;
  assign bus.evt_valid  = r_evt_valid;
  assign bus.evt_id     = r_evt_id;
  assign bus.evt_time   = r_evt_time;
  assign bus.now        = r_now;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_fork_join_dispatcher.sv
// Bench for fork_join_dispatcher: table of fork commands with expected join cycle and
// event stream, plus hand-written mid-run reset and timestamp-wrap sequences.
module tb_fork_join_dispatcher;
  import fork_join_pkg::*;

  localparam int NJ   = 4;
  localparam int DW   = 8;
  localparam int TW   = 16;
  localparam int IW   = 2;
  localparam int TW4  = 4;
  localparam int SB_W = IW + TW + 8;

  // Event k of a vector: id, completion offset from T, cycle offset of its pop.
  typedef struct packed {
    logic [1:0]               mode;
    logic [NJ-1:0]            en;
    logic [NJ-1:0][DW-1:0]    d;
    int                       bp;
    int                       join_off;
    int                       n_ev;
    logic [3:0][IW-1:0]       ev_id;
    logic [3:0][7:0]          ev_t;
    logic [3:0][7:0]          ev_c;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  int             cyc = 0;
  int             n_checks = 0;
  int             n_err = 0;
  logic [SB_W-1:0] exp_q[$];
  vec_t           vecs [7];
  state_t         dbg_state;
  state_t         dbg_state4;

  fork_join_dispatcher_if #(.NUM_JOBS(NJ), .DELAY_W(DW), .TIME_W(TW),  .ID_W(IW)) bus  ();
  fork_join_dispatcher_if #(.NUM_JOBS(NJ), .DELAY_W(DW), .TIME_W(TW4), .ID_W(IW)) bus4 ();

  fork_join_dispatcher #(.NUM_JOBS(NJ), .DELAY_W(DW), .TIME_W(TW), .ID_W(IW)) u_dut (
    .clk(clk), .rst(rst), .bus(bus), .o_dbg_state(dbg_state)
  );

  fork_join_dispatcher #(.NUM_JOBS(NJ), .DELAY_W(DW), .TIME_W(TW4), .ID_W(IW)) u_dut4 (
    .clk(clk), .rst(rst), .bus(bus4), .o_dbg_state(dbg_state4)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic [1:0] mode, input logic [3:0] en,
                              input logic [31:0] d, input int bp, input int jo, input int n,
                              input logic [7:0] ids, input logic [31:0] ts, input logic [31:0] cs);
    vec_t v;
    v.mode = mode; v.en = en; v.d = d; v.bp = bp; v.join_off = jo; v.n_ev = n;
    v.ev_id = ids; v.ev_t = ts; v.ev_c = cs;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic reset_seq(input int n);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    #1;
    check("ready_in_rst", 64'(bus.fork_ready), 64'(0));
    rst = 1'b0;
    #1;
    check("rst_ready",     64'(bus.fork_ready), 64'(1));
    check("rst_now",       64'(bus.now),        64'(0));
    check("rst_busy",      64'(bus.busy),       64'(0));
    check("rst_evt_valid", 64'(bus.evt_valid),  64'(0));
    check("rst_evt_id",    64'(bus.evt_id),     64'(0));
    check("rst_evt_time",  64'(bus.evt_time),   64'(0));
    check("rst_join",      64'(bus.join_done),  64'(0));
    check("rst_state",     64'(dbg_state),      64'(IDLE));
    check("rst_now4",      64'(bus4.now),       64'(0));
    check("rst_state4",    64'(dbg_state4),     64'(IDLE));
  endtask

  task automatic wait_ready();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (bus.fork_ready) begin ok = 1'b1; break; end
    end
    check("fork_ready_wait", 64'(ok), 64'(1));
  endtask

  // driver + monitor for one table vector
  task automatic run_vec(input int vi, input vec_t v);
    int                    t0, joins, join_at;
    bit                    ret, early, prev_stall;
    logic [TW-1:0]         now0, prev_t;
    logic [IW-1:0]         prev_id;
    logic [NJ-1:0][DW-1:0] d;
    logic [SB_W-1:0]       got, want;
    string                 tag;
    joins = 0; join_at = -1; ret = 1'b0; early = 1'b0; prev_stall = 1'b0;
    prev_t = '0; prev_id = '0;
    tag = $sformatf("v%0d", vi);
    wait_ready();
    d = v.d;
    for (int j = 0; j < NJ; j++) if (!v.en[j]) d[j] = DW'($urandom_range(0, 255));
    bus.fork_mode  = v.mode;
    bus.fork_en    = v.en;
    bus.fork_delay = d;
    bus.fork_valid = 1'b1;
    bus.evt_ready  = (v.bp > 0) ? 1'b0 : 1'b1;
    t0 = cyc;
    now0 = bus.now;
    for (int e = 0; e < v.n_ev; e++)
      exp_q.push_back({v.ev_id[e], TW'(now0 + TW'(v.ev_t[e])), v.ev_c[e]});
    for (int k = 0; k <= 60; k++) begin
      if (k > 0) begin
        @(negedge clk);
        bus.fork_valid = 1'b0;
        bus.evt_ready  = (v.bp > 0 && k <= v.bp) ? 1'b0 : 1'b1;
        #1;
      end
      if (bus.join_done) begin joins++; join_at = k; end
      if (prev_stall)
        check({tag, "_evt_hold"}, 64'({bus.evt_valid, bus.evt_id, bus.evt_time}),
              64'({1'b1, prev_id, prev_t}));
      prev_stall = bus.evt_valid && !bus.evt_ready;
      prev_id    = bus.evt_id;
      prev_t     = bus.evt_time;
      if (bus.evt_valid && bus.evt_ready) begin
        got = {bus.evt_id, bus.evt_time, 8'(k)};
        if (exp_q.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL %s_evt_extra: got %0h expected no event", tag, got);
        end else begin
          want = exp_q.pop_front();
          check({tag, "_evt"}, 64'(got), 64'(want));
        end
      end
      if (k > 0 && exp_q.size() != 0 && bus.fork_ready) early = 1'b1;
      if (k > v.join_off && exp_q.size() == 0 && bus.fork_ready) begin ret = 1'b1; break; end
    end
    check({tag, "_join_count"},  64'(joins),        64'(1));
    check({tag, "_join_cycle"},  64'(join_at),      64'(v.join_off));
    check({tag, "_events_left"}, 64'(exp_q.size()), 64'(0));
    exp_q.delete();
    if (v.n_ev > 0) check({tag, "_ready_low"}, 64'(early), 64'(0));
    check({tag, "_ready_return"}, 64'(ret), 64'(1));
    check({tag, "_now_count"}, 64'(bus.now), 64'(TW'(now0 + TW'(cyc - t0))));
  endtask

  initial begin : main
    int              evs, joins, join_at, busy_seen;
    logic [TW-1:0]   now0;
    logic [SB_W-1:0] got, want;

    bus.fork_valid = 1'b0;  bus.fork_mode = 2'd0;  bus.fork_en = '0;
    bus.fork_delay = '0;    bus.evt_ready = 1'b1;
    bus4.fork_valid = 1'b0; bus4.fork_mode = 2'd0; bus4.fork_en = '0;
    bus4.fork_delay = '0;   bus4.evt_ready = 1'b1;

    vecs[0] = mk(2'd2, 4'hF, {8'd5, 8'd15, 8'd10, 8'd5}, 0, 1, 4,
                 {2'd2, 2'd1, 2'd3, 2'd0}, {8'd15, 8'd10, 8'd5, 8'd5}, {8'd16, 8'd11, 8'd7, 8'd6});
    vecs[1] = mk(2'd0, 4'hF, {8'd5, 8'd15, 8'd10, 8'd5}, 0, 15, 4,
                 {2'd2, 2'd1, 2'd3, 2'd0}, {8'd15, 8'd10, 8'd5, 8'd5}, {8'd16, 8'd11, 8'd7, 8'd6});
    vecs[2] = mk(2'd1, 4'hF, {8'd5, 8'd15, 8'd10, 8'd5}, 0, 5, 4,
                 {2'd2, 2'd1, 2'd3, 2'd0}, {8'd15, 8'd10, 8'd5, 8'd5}, {8'd16, 8'd11, 8'd7, 8'd6});
    vecs[3] = mk(2'd0, 4'hF, {8'd5, 8'd15, 8'd10, 8'd5}, 20, 15, 4,
                 {2'd3, 2'd2, 2'd1, 2'd0}, {8'd5, 8'd15, 8'd10, 8'd5}, {8'd24, 8'd23, 8'd22, 8'd21});
    vecs[4] = mk(2'd0, 4'b0100, {8'd9, 8'd0, 8'd9, 8'd9}, 0, 1, 1,
                 {2'd0, 2'd0, 2'd0, 2'd2}, {8'd0, 8'd0, 8'd0, 8'd1}, {8'd0, 8'd0, 8'd0, 8'd2});
    vecs[5] = mk(2'd1, 4'b0000, 32'h0, 0, 1, 0, 8'h0, 32'h0, 32'h0);
    vecs[6] = mk(2'd3, 4'b0011, {8'd0, 8'd0, 8'd7, 8'd3}, 0, 7, 2,
                 {2'd0, 2'd0, 2'd1, 2'd0}, {8'd0, 8'd0, 8'd7, 8'd3}, {8'd0, 8'd0, 8'd8, 8'd4});

    reset_seq(3);

    for (int vi = 0; vi < 7; vi++) run_vec(vi, vecs[vi]);

    // reset in the middle of a JOIN_ALL run
    wait_ready();
    bus.fork_mode  = 2'd0;
    bus.fork_en    = 4'hF;
    bus.fork_delay = {8'd5, 8'd15, 8'd10, 8'd5};
    bus.fork_valid = 1'b1;
    bus.evt_ready  = 1'b0;
    now0 = bus.now;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      bus.fork_valid = 1'b0;
      #1;
      if (k == 6)
        check("mid_evt_before_rst", 64'({bus.evt_valid, bus.evt_id, bus.evt_time}),
              64'({1'b1, 2'd0, TW'(now0 + TW'(5))}));
    end
    reset_seq(2);
    bus.evt_ready = 1'b1;
    evs = 0; joins = 0; busy_seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk); #1;
      if (bus.evt_valid) evs++;
      if (bus.join_done) joins++;
      if (bus.busy != '0) busy_seen++;
    end
    check("rst_no_events",  64'(evs),       64'(0));
    check("rst_no_join",    64'(joins),     64'(0));
    check("rst_busy_clear", 64'(busy_seen), 64'(0));

    // timestamp wrap on the 4-bit time instance
    for (int i = 0; i < 40; i++) begin
      if (bus4.now == TW4'(14) && bus4.fork_ready) break;
      @(negedge clk); #1;
    end
    check("wrap_start_now", 64'(bus4.now), 64'(14));
    bus4.fork_mode  = 2'd0;
    bus4.fork_en    = 4'b0001;
    bus4.fork_delay = {8'd0, 8'd0, 8'd0, 8'd3};
    bus4.fork_valid = 1'b1;
    bus4.evt_ready  = 1'b1;
    exp_q.push_back({2'd0, 16'd1, 8'd4});
    joins = 0; join_at = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      bus4.fork_valid = 1'b0;
      #1;
      if (bus4.join_done) begin joins++; join_at = k; end
      if (bus4.evt_valid && bus4.evt_ready) begin
        got = {bus4.evt_id, TW'(bus4.evt_time), 8'(k)};
        if (exp_q.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL wrap_evt_extra: got %0h expected no event", got);
        end else begin
          want = exp_q.pop_front();
          check("wrap_evt", 64'(got), 64'(want));
        end
      end
    end
    check("wrap_join_count",  64'(joins),        64'(1));
    check("wrap_join_cycle",  64'(join_at),      64'(3));
    check("wrap_events_left", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
